// File: rtl/psum_drain.sv
// psum_drain: reads a range of PSUM memory rows and streams each row's
// signed partial-sum lanes to a host-side consumer over valid/ready.
// Build option: define PSUM_DRAIN_SUM_EN to append a per-row lane-sum beat.
module psum_drain #(
    parameter int bw_psum = 19,
    parameter int col     = 8,
    parameter int addr_w  = 4,
    parameter int ow      = bw_psum + 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [addr_w-1:0]      base_add,
    input  logic [addr_w:0]        row_cnt,
    output logic                   pmem_rd,
    output logic [addr_w-1:0]      pmem_add,
    input  logic [col*bw_psum-1:0] pmem_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ow-1:0]          out_data,
    output logic [3:0]             out_lane,
    output logic [addr_w-1:0]      out_row,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        SEND,
        DONE
    } state_t;

    // Index of the final beat of a row: the sum beat when enabled.
`ifdef PSUM_DRAIN_SUM_EN
    localparam logic [3:0] last_lane = 4'(col);
`else
    localparam logic [3:0] last_lane = 4'(col - 1);
`endif

    state_t                   state_q;
    state_t                   state_d;
    logic [addr_w-1:0]        cur_row;
    logic [addr_w:0]          rows_left;
    logic [3:0]               lane;
    logic [col*bw_psum-1:0]   word_reg;
    logic [bw_psum-1:0]       lane_val;
    logic [ow-1:0]            lane_ext;
    logic                     xfer;
    logic                     row_end;
    logic                     more_rows;

    assign xfer      = (state_q == SEND) && out_ready;
    assign row_end   = (lane == last_lane);
    assign more_rows = (rows_left > (addr_w + 1)'(1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values; blocking here would create ordering races.
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and control outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        state_d   = state_q;
        pmem_rd   = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = (row_cnt != '0) ? RD : DONE;
            end
            RD: begin
                pmem_rd = 1'b1;
                state_d = CAP;
            end
            CAP: state_d = SEND;
            SEND: begin
                out_valid = 1'b1;
                out_last  = row_end && !more_rows;
                if (xfer && row_end) state_d = more_rows ? RD : DONE;
            end
            DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Command latch, row/lane counters and captured memory word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_row   <= '0;
            rows_left <= '0;
            lane      <= '0;
            // NOTE: word_reg is a plain register, not a RAM, so it is reset
            // cheaply and outputs are clean zero after reset.
            word_reg  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && row_cnt != '0) begin
                        cur_row   <= base_add;
                        rows_left <= row_cnt;
                    end
                end
                CAP: begin
                    word_reg <= pmem_out;
                    lane     <= '0;
                end
                SEND: begin
                    if (xfer) begin
                        if (row_end) begin
                            lane <= '0;
                            if (more_rows) begin
                                // Row address wraps modulo 2^addr_w.
                                cur_row   <= cur_row + 1'b1;
                                rows_left <= rows_left - 1'b1;
                            end
                        end else begin
                            lane <= lane + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Select the current lane from the captured word.
    always_comb begin
        lane_val = '0;
        for (int i = 0; i < col; i++) begin
            if (lane == 4'(i)) lane_val = word_reg[i*bw_psum +: bw_psum];
        end
    end

    assign lane_ext = {{(ow - bw_psum){lane_val[bw_psum-1]}}, lane_val};

`ifdef PSUM_DRAIN_SUM_EN
    logic [ow-1:0] row_sum;

    // Signed sum of all sign-extended lanes; ow bits cannot overflow.
    always_comb begin
        row_sum = '0;
        for (int i = 0; i < col; i++) begin
            row_sum = row_sum + {{(ow - bw_psum){word_reg[(i+1)*bw_psum-1]}},
                                 word_reg[i*bw_psum +: bw_psum]};
        end
    end

    assign out_data = (state_q != SEND)  ? '0 :
                      (lane == 4'(col))  ? row_sum : lane_ext;
`else
    assign out_data = (state_q == SEND) ? lane_ext : '0;
`endif

    // The read address holds between reads because cur_row only moves
    // when another row is about to be read.
    assign pmem_add = cur_row;
    assign out_lane = (state_q == SEND) ? lane : 4'd0;
    assign out_row  = (state_q == SEND) ? cur_row : '0;

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: scoreboard bench for psum_drain. A behavioural PSUM
// memory feeds the DUT; expected beats and read addresses are queued when
// a command is issued and popped as the DUT produces them.
module tb_psum_drain;

    localparam int BW  = 19;
    localparam int COL = 8;
    localparam int AW  = 4;
    localparam int OW  = BW + 4;
`ifdef PSUM_DRAIN_SUM_EN
    localparam bit SUM = 1'b1;
`else
    localparam bit SUM = 1'b0;
`endif

    logic              clk       = 1'b0;
    logic              reset     = 1'b0;
    logic              start     = 1'b0;
    logic [AW-1:0]     base_add  = '0;
    logic [AW:0]       row_cnt   = '0;
    logic              pmem_rd;
    logic [AW-1:0]     pmem_add;
    logic [COL*BW-1:0] pmem_out  = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OW-1:0]     out_data;
    logic [3:0]        out_lane;
    logic [AW-1:0]     out_row;
    logic              out_last;
    logic              busy;
    logic              done;

    typedef struct {
        logic [OW-1:0] data;
        logic [3:0]    lane;
        logic [AW-1:0] row;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic [COL*BW-1:0] mem [16];
    int n_checks = 0;
    int n_pass   = 0;

    psum_drain #(.bw_psum(BW), .col(COL), .addr_w(AW), .ow(OW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base_add (base_add),
        .row_cnt  (row_cnt),
        .pmem_rd  (pmem_rd),
        .pmem_add (pmem_add),
        .pmem_out (pmem_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_lane (out_lane),
        .out_row  (out_row),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // PSUM memory with one-cycle read latency.
    always @(posedge clk) begin
        if (pmem_rd) pmem_out <= mem[pmem_add];
    end

    task automatic set_lane(input int a, input int i, input logic [BW-1:0] v);
        mem[a][i*BW +: BW] = v;
    endtask

    task automatic fill_basic();
        for (int r = 0; r < 16; r++)
            for (int i = 0; i < COL; i++)
                set_lane(r, i, BW'(r * 8 + i));
    endtask

    // Queue expected reads and beats for a command.
    task automatic push_cmd(input logic [AW-1:0] b, input int n);
        logic [AW-1:0] a;
        logic [OW-1:0] sum;
        logic [BW-1:0] v;
        beat_t         e;
        for (int r = 0; r < n; r++) begin
            a = b + AW'(r);
            addr_q.push_back(a);
            sum = '0;
            for (int i = 0; i < COL; i++) begin
                v      = mem[a][i*BW +: BW];
                e.data = OW'($signed(v));
                e.lane = 4'(i);
                e.row  = a;
                e.last = (r == n - 1) && (i == COL - 1) && !SUM;
                sum    = sum + e.data;
                exp_q.push_back(e);
            end
            if (SUM) begin
                e.data = sum;
                e.lane = 4'(COL);
                e.row  = a;
                e.last = (r == n - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Issue a command and drain it, comparing every read and beat.
    // inj_at: cycle to pulse a spurious start; abort_at: cycle to assert reset.
    task automatic drain(input string name, input logic [AW-1:0] b, input int n,
                         input bit bp, input int inj_at, input int abort_at);
        logic [3:0] pat = 4'b1001;
        bit fin = 1'b0;
        bit stalled = 1'b0;
        bit last_prev = 1'b0;
        bit last_now;
        beat_t e;
        logic [AW-1:0] ea;
        push_cmd(b, n);
        @(negedge clk);
        start = 1'b1; base_add = b; row_cnt = (AW + 1)'(n);
        for (int k = 0; k < 2000 && !fin; k++) begin
            @(negedge clk);
            start = (k == inj_at);
            if (k == inj_at) begin base_add = 4'd9; row_cnt = 5'd3; end
            out_ready = bp ? pat[k % 4] : 1'b1;
            last_now = 1'b0;
            if (k == abort_at) begin
                reset = 1'b0;
                #1;
                n_checks++;
                if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || pmem_rd !== 1'b0)
                    $display("FAIL %s abort: busy=%0b valid=%0b done=%0b rd=%0b, expected all 0",
                             name, busy, out_valid, done, pmem_rd);
                else n_pass++;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    n_checks++;
                    if (done !== 1'b0) $display("FAIL %s abort_done: done=%0b expected 0", name, done);
                    else n_pass++;
                end
                reset = 1'b1;
                exp_q.delete();
                addr_q.delete();
                fin = 1'b1;
            end else begin
                if (stalled) begin
                    n_checks++;
                    if (out_valid !== 1'b1) $display("FAIL %s valid_drop: out_valid=%0b expected 1", name, out_valid);
                    else n_pass++;
                end
                if (pmem_rd) begin
                    n_checks++;
                    if (addr_q.size() == 0)
                        $display("FAIL %s read: pmem_rd with addr %0d, expected no read", name, pmem_add);
                    else begin
                        ea = addr_q.pop_front();
                        if (pmem_add !== ea) $display("FAIL %s read_addr: got %0d expected %0d", name, pmem_add, ea);
                        else n_pass++;
                    end
                end
                if (out_valid) begin
                    n_checks++;
                    if (exp_q.size() == 0)
                        $display("FAIL %s beat: unexpected beat data=%0h lane=%0d, expected none", name, out_data, out_lane);
                    else begin
                        e = exp_q[0];
                        if (out_data !== e.data || out_lane !== e.lane || out_row !== e.row || out_last !== e.last)
                            $display("FAIL %s beat: got data=%0h lane=%0d row=%0d last=%0b expected data=%0h lane=%0d row=%0d last=%0b",
                                     name, out_data, out_lane, out_row, out_last, e.data, e.lane, e.row, e.last);
                        else n_pass++;
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            last_now = out_last;
                        end
                    end
                end
                stalled = out_valid && !out_ready;
                if (done) begin
                    n_checks++;
                    if (!(n == 0 ? (k == 0) : last_prev) || exp_q.size() != 0 ||
                        addr_q.size() != 0 || busy !== 1'b0)
                        $display("FAIL %s done: cycle=%0d last_prev=%0b beats_left=%0d reads_left=%0d busy=%0b, expected done after final beat",
                                 name, k, last_prev, exp_q.size(), addr_q.size(), busy);
                    else n_pass++;
                    fin = 1'b1;
                end
                last_prev = last_now;
            end
        end
        if (!fin) begin
            n_checks++;
            $display("FAIL %s timeout: no done within budget, expected done", name);
            exp_q.delete();
            addr_q.delete();
        end
        start = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (pmem_rd !== 1'b0 || pmem_add !== '0 || out_valid !== 1'b0 || out_data !== '0 ||
            out_lane !== '0 || out_row !== '0 || out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset: rd=%0b add=%0d valid=%0b data=%0h lane=%0d row=%0d last=%0b busy=%0b done=%0b, expected all 0",
                     pmem_rd, pmem_add, out_valid, out_data, out_lane, out_row, out_last, busy, done);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        fill_basic();
        drain("basic", 4'd0, 8, 1'b0, -1, -1);
    endtask

    task automatic test_sign();
        fill_basic();
        set_lane(3, 0, 19'h7FFFF);
        set_lane(3, 7, 19'h40000);
        drain("sign", 4'd3, 1, 1'b0, -1, -1);
    endtask

    task automatic test_backpressure();
        fill_basic();
        drain("backpressure", 4'd0, 8, 1'b1, -1, -1);
    endtask

    task automatic test_wrap();
        fill_basic();
        drain("wrap", 4'd14, 4, 1'b0, -1, -1);
    endtask

    task automatic test_zero();
        drain("zero", 4'd5, 0, 1'b0, -1, -1);
    endtask

    task automatic test_ignored_start();
        fill_basic();
        drain("ignored_start", 4'd0, 8, 1'b0, 24, -1);
    endtask

    task automatic test_reset_abort();
        fill_basic();
        drain("abort", 4'd0, 8, 1'b0, -1, 54);
        drain("after_abort", 4'd2, 3, 1'b0, -1, -1);
    endtask

    task automatic test_sum();
        int v[COL] = '{-5, 3, 100, -100, 7, 0, 1, -1};
        for (int i = 0; i < COL; i++) set_lane(6, i, BW'(v[i]));
        drain("sum", 4'd6, 1, 1'b0, -1, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign();
        test_backpressure();
        test_wrap();
        test_zero();
        test_ignored_start();
        test_reset_abort();
        if (SUM) test_sum();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
